// File: rtl/hw_led_driver_if.sv
// ============================================================================
// Module      : hw_led_driver_if
// Description : Avalon-MM register-port bundle for the LED driver.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface hw_led_driver_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

`default_nettype wire

// File: rtl/hw_led_driver.sv
// ============================================================================
// Module      : hw_led_driver
// Description : LED post-processor with PWM dimming, per-bit blink and invert.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hw_led_driver (
    input  logic                  clk,
    input  logic                  reset_n,
    hw_led_driver_if.slave        bus,
    input  logic [7:0]            led_in,
    output logic [7:0]            led_out
);

    localparam logic [1:0] c_ADDR_CTRL     = 2'd0;
    localparam logic [1:0] c_ADDR_PRESCALE = 2'd1;
    localparam logic [1:0] c_ADDR_DUTY     = 2'd2;
    localparam logic [1:0] c_ADDR_BLINK    = 2'd3;
    localparam logic [7:0] c_PWM_LAST      = 8'd254;

    logic        r_enable;
    logic        r_invert;
    logic [15:0] r_prescale;
    logic [7:0]  r_duty;
    logic [7:0]  r_mask;
    logic [7:0]  r_div;

    logic [15:0] r_presc_cnt;
    logic [7:0]  r_pwm_cnt;
    logic [7:0]  r_blink_cnt;
    logic        r_blink_phase;

    logic        w_wr;
    logic        w_disable_wr;
    logic        w_run;
    logic        w_tick;
    logic        w_period_end;
    logic        w_blink_wrap;
    logic        w_pwm_on;
    logic [7:0]  w_led_next;
    logic        w_unused_wdata;

    assign w_wr           = bus.chipselect & ~bus.write_n;
    assign w_unused_wdata = &{1'b0, bus.writedata[31:16]};

    // A write that clears enable wins over any tick/period_end in the same cycle.
    assign w_disable_wr = w_wr && (bus.address == c_ADDR_CTRL) && !bus.writedata[0];
    assign w_run        = r_enable & ~w_disable_wr;

    // ">=" rather than "==" so a limit lowered below the count acts at once.
    assign w_tick       = r_enable && (r_presc_cnt >= r_prescale);
    assign w_period_end = w_tick && (r_pwm_cnt >= c_PWM_LAST);
    assign w_blink_wrap = w_period_end && (r_blink_cnt >= r_div);
    assign w_pwm_on     = (r_pwm_cnt < r_duty);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_enable   <= 1'b0;
            r_invert   <= 1'b0;
            r_prescale <= 16'd0;
            r_duty     <= 8'd0;
            r_mask     <= 8'd0;
            r_div      <= 8'd0;
        end else if (w_wr) begin
            case (bus.address)
                c_ADDR_CTRL: begin
                    r_enable <= bus.writedata[0];
                    r_invert <= bus.writedata[1];
                end
                c_ADDR_PRESCALE: r_prescale <= bus.writedata[15:0];
                c_ADDR_DUTY:     r_duty     <= bus.writedata[7:0];
                c_ADDR_BLINK: begin
                    r_mask <= bus.writedata[7:0];
                    r_div  <= bus.writedata[15:8];
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_presc_cnt   <= 16'd0;
            r_pwm_cnt     <= 8'd0;
            r_blink_cnt   <= 8'd0;
            r_blink_phase <= 1'b0;
        end else if (!w_run) begin
            r_presc_cnt   <= 16'd0;
            r_pwm_cnt     <= 8'd0;
            r_blink_cnt   <= 8'd0;
            r_blink_phase <= 1'b0;
        end else begin
            r_presc_cnt <= w_tick ? 16'd0 : r_presc_cnt + 16'd1;
            if (w_period_end) begin
                r_pwm_cnt <= 8'd0;
            end else if (w_tick) begin
                r_pwm_cnt <= r_pwm_cnt + 8'd1;
            end
            if (w_blink_wrap) begin
                r_blink_cnt   <= 8'd0;
                r_blink_phase <= ~r_blink_phase;
            end else if (w_period_end) begin
                r_blink_cnt <= r_blink_cnt + 8'd1;
            end
        end
    end

    assign w_led_next = r_enable
        ? ((led_in & {8{w_pwm_on}} & ~(r_mask & {8{r_blink_phase}})) ^ {8{r_invert}})
        : {8{r_invert}};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            led_out <= 8'h00;
        end else begin
            led_out <= w_led_next;
        end
    end

    always_comb begin
        bus.readdata = 32'd0;
        case (bus.address)
            c_ADDR_CTRL:     bus.readdata = {30'd0, r_invert, r_enable};
            c_ADDR_PRESCALE: bus.readdata = {16'd0, r_prescale};
            c_ADDR_DUTY:     bus.readdata = {24'd0, r_duty};
            c_ADDR_BLINK:    bus.readdata = {16'd0, r_div, r_mask};
            default:         bus.readdata = 32'd0;
        endcase
    end

endmodule

`default_nettype wire

// File: doc/hw_led_driver.md
HW_LED_DRIVER -- requirements
Module: hw_led_driver

Interface
REQ-001 The block SHALL have no parameters; LED width is fixed at 8, register data width at 32.
REQ-002 The block SHALL have port clk, input, 1 bit: single clock for all logic.
REQ-003 The block SHALL have port reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port address, input, 2 bits: Avalon-MM register select.
REQ-005 The block SHALL have port chipselect, input, 1 bit: slave select.
REQ-006 The block SHALL have port write_n, input, 1 bit: active-low write strobe.
REQ-007 The block SHALL have port writedata, input, 32 bits: write data.
REQ-008 The block SHALL have port readdata, output, 32 bits: read data, zero-extended.
REQ-009 The block SHALL have port led_in, input, 8 bits: LED pattern from the upstream LED PIO out_port.
REQ-010 The block SHALL have port led_out, output, 8 bits: drive to the board LED pins.

Function
REQ-011 A register write SHALL occur on a rising clk edge with chipselect=1 and write_n=0; the target is selected by address.
REQ-012 Register map: 0 CTRL (bit0 enable, bit1 invert); 1 PRESCALE[15:0]; 2 DUTY[7:0]; 3 BLINK (bits[7:0] mask, bits[15:8] div); unused bits SHALL be ignored on write and read as 0.
REQ-013 readdata SHALL be combinational from address: it is the selected register zero-extended to 32 bits, independent of chipselect, with no read side effects.
REQ-014 Prescaler presc_cnt (16 bits): while enabled it increments each cycle; when presc_cnt >= PRESCALE it SHALL assert tick for that cycle and reload 0, giving one tick every PRESCALE+1 cycles.
REQ-015 PWM counter pwm_cnt (8 bits): it increments on tick; on tick at value 254 it SHALL wrap to 0 and assert period_end, giving a period of 255 ticks.
REQ-016 pwm_on SHALL be (pwm_cnt < DUTY): DUTY=0 means always off; DUTY=255 means always on.
REQ-017 Blink counter blink_cnt (8 bits): it increments on period_end; when blink_cnt >= div on period_end it SHALL reload 0 and toggle blink_phase.
REQ-018 The ">=" comparisons in REQ-014 and REQ-017 SHALL make a limit rewritten below the current count take effect at the next evaluation, with no wrap through the full range.
REQ-019 When enabled, led_out[i] SHALL be registered as (led_in[i] & pwm_on & ~(mask[i] & blink_phase)) ^ invert, one clk of latency from inputs and counters.
REQ-020 When disabled, presc_cnt, pwm_cnt, blink_cnt and blink_phase SHALL be held at 0, and led_out SHALL be {8{invert}} on the next edge.
REQ-021 A write clearing enable SHALL take priority over any same-cycle tick or period_end; counters SHALL be 0 on the following cycle.
REQ-022 Register writes SHALL take effect on the cycle after the write edge; counters SHALL NOT be reset by writes to PRESCALE, DUTY or BLINK.

Reset
REQ-023 While reset_n=0, all registers, counters and blink_phase SHALL be 0 and led_out SHALL be 8'h00, immediately and independent of clk.
REQ-024 After reset deasserts, the block SHALL remain disabled until CTRL.enable is written to 1.
REQ-025 Reset asserted mid-period SHALL abort the PWM and blink cycles; operation after re-enable SHALL start from count 0.

Verification
REQ-026 Reset and readback: release reset, read addresses 0-3 -> all 0 and led_out=00; write PRESCALE=0x1234ABCD -> reads 0x0000ABCD.
REQ-027 Full-on path: led_in=A5, DUTY=255, PRESCALE=0, CTRL=1 -> led_out=A5 from the second cycle after the CTRL write, constant thereafter.
REQ-028 PWM duty: led_in=FF, DUTY=64, PRESCALE=3 -> each 1020-cycle period has led_out=FF for exactly 256 cycles and 00 for 764 cycles.
REQ-029 Blink: DUTY=255, PRESCALE=0, BLINK=0x0103 (div=1, mask=03), led_in=0F -> led_out alternates 0F/0C every 510 cycles.
REQ-030 Invert/disable: CTRL=3 with DUTY=0 -> led_out=FF; then CTRL=2 -> led_out=FF and counters read back as 0 via probe; then CTRL=0 -> 00.
REQ-031 Boundary: with presc_cnt=200 and PRESCALE=1000, write PRESCALE=10 -> tick on the cycle after the write, then every 11 cycles; reset_n pulsed mid-period -> led_out=00 immediately.
